// File: rtl/seqdet_core_if.sv
// Serial-detector signal bundle: data bit in, state/flag (and optional count) out.
// The det_cnt signal exists only when SEQDET_CNT_EN is defined.
interface seqdet_core_if #(
    parameter int unsigned CNT_W = 8
);
    logic             x;
    logic             z;
    logic             q1;
    logic             q0;
`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] det_cnt;

    modport master (output x, input z, input q1, input q0, input det_cnt);
    modport slave  (input x, output z, output q1, output q0, output det_cnt);
`else
    modport master (output x, input z, input q1, input q0);
    modport slave  (input x, output z, output q1, output q0);
`endif
endinterface

// File: rtl/seqdet_core.sv
// Moore FSM detecting serial pattern 1,1,0 with overlap; z flags the DET state.
// Optional saturating detection counter enabled by macro SEQDET_CNT_EN.
module seqdet_core #(
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    seqdet_core_if.slave  bus
);

    localparam logic [1:0] S0  = 2'b00;
    localparam logic [1:0] S1  = 2'b01;
    localparam logic [1:0] S11 = 2'b10;
    localparam logic [1:0] DET = 2'b11;

    logic [1:0] state_q, state_d;
    logic       z_q, z_d;

    // Next state; z is registered from the next state so it always equals (state_q == DET).
    always_comb begin
        state_d = S0;
        z_d     = 1'b0;
        case (state_q)
            S0:      state_d = bus.x ? S1  : S0;
            S1:      state_d = bus.x ? S11 : S0;
            S11:     state_d = bus.x ? S11 : DET;
            DET:     state_d = bus.x ? S1  : S0;
            default: state_d = S0;
        endcase
        z_d = (state_d == DET);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign bus.q1 = state_q[1];
    assign bus.q0 = state_q[0];
    assign bus.z  = z_q;

`ifdef SEQDET_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;

    // Count entries into DET, holding at all-ones.
    always_comb begin
        det_cnt_d = det_cnt_q;
        if ((state_d == DET) && (det_cnt_q != CNT_MAX)) begin
            det_cnt_d = det_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            det_cnt_q <= '0;
        end else begin
            det_cnt_q <= det_cnt_d;
        end
    end

    assign bus.det_cnt = det_cnt_q;
`endif

endmodule

// File: tb/tb_seqdet_core.sv
// Scoreboard bench for seqdet_core: a bit-history model predicts state, z and counts.
// Two instances (CNT_W=8 and CNT_W=2) share the same stimulus.
module tb_seqdet_core;

    localparam logic [1:0] S0  = 2'b00;
    localparam logic [1:0] S1  = 2'b01;
    localparam logic [1:0] S11 = 2'b10;
    localparam logic [1:0] DET = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic       z;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    logic clk;
    logic rst;

    seqdet_core_if #(.CNT_W(8)) bus8 ();
    seqdet_core_if #(.CNT_W(2)) bus2 ();

    seqdet_core #(.CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus8.slave)
    );

    seqdet_core #(.CNT_W(2)) u_dut_w2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        sb_q[$];
    logic [2:0]  hist    = 3'b000;
    int unsigned m_cnt8  = 0;
    int unsigned m_cnt2  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit (and reset), predict from bit history, compare after the edge.
    task automatic step(input logic xin, input logic rin, input string tag);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        rst    = rin;
        bus8.x = xin;
        bus2.x = xin;
        if (rin) begin
            hist   = 3'b000;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else begin
            hist = {hist[1:0], xin};
        end
        if (hist[0]) e.st = hist[1] ? S11 : S1;
        else         e.st = (hist[2] && hist[1]) ? DET : S0;
        e.z = (e.st == DET);
        if (!rin && e.z) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
        end
        e.cnt8 = 8'(m_cnt8);
        e.cnt2 = 2'(m_cnt2);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check({tag, ".st"},   32'({bus8.q1, bus8.q0}), 32'(got_e.st));
        check({tag, ".z"},    32'(bus8.z),             32'(got_e.z));
        check({tag, ".st2"},  32'({bus2.q1, bus2.q0}), 32'(got_e.st));
        check({tag, ".z2"},   32'(bus2.z),             32'(got_e.z));
`ifdef SEQDET_CNT_EN
        check({tag, ".cnt8"}, 32'(bus8.det_cnt),       32'(got_e.cnt8));
        check({tag, ".cnt2"}, 32'(bus2.det_cnt),       32'(got_e.cnt2));
`endif
    endtask

    task automatic detect3(input string tag);
        step(1'b1, 1'b0, tag);
        step(1'b1, 1'b0, tag);
        step(1'b0, 1'b0, tag);
    endtask

    logic       seq22 [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] st22  [11] = '{S1, S0, S0, S1, S0, S1, S11, DET, S1, S11, S11};
    logic       seq24 [7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       z24   [7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst    = 1'b1;
        bus8.x = 1'b0;
        bus2.x = 1'b0;

        // Reset held with both x values
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2), 1'b1, "rst_hold");
            check("rst_hold.q", 32'({bus8.q1, bus8.q0, bus8.z}), 32'd0);
        end

        // Mixed sequence with a directed state table
        for (int i = 0; i < 11; i++) begin
            step(seq22[i], 1'b0, "seq22");
            check("seq22.tbl", 32'({bus8.q1, bus8.q0}), 32'(st22[i]));
        end

        // Long run of ones then zero: one detection
        step(1'b0, 1'b1, "rst");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "run1");
        step(1'b0, 1'b0, "run0");
        check("run.z_on", 32'(bus8.z), 32'd1);
        step(1'b0, 1'b0, "run_after");
        check("run.z_off", 32'(bus8.z), 32'd0);
`ifdef SEQDET_CNT_EN
        check("run.cnt", 32'(bus8.det_cnt), 32'd1);
`endif

        // Two detections three cycles apart
        step(1'b0, 1'b1, "rst");
        for (int i = 0; i < 7; i++) begin
            step(seq24[i], 1'b0, "seq24");
            check("seq24.z", 32'(bus8.z), 32'(z24[i]));
        end
`ifdef SEQDET_CNT_EN
        check("seq24.cnt", 32'(bus8.det_cnt), 32'd2);
`endif

        // Reset while in DET
        detect3("pre_det");
        check("pre_det.st", 32'({bus8.q1, bus8.q0}), 32'(DET));
        step(1'b1, 1'b1, "rst_in_det");
        check("rst_in_det.q", 32'({bus8.q1, bus8.q0, bus8.z}), 32'd0);
`ifdef SEQDET_CNT_EN
        check("rst_in_det.cnt", 32'(bus8.det_cnt), 32'd0);
`endif

        // Five detections saturate the 2-bit counter
        for (int i = 0; i < 5; i++) detect3("sat2");
`ifdef SEQDET_CNT_EN
        check("sat2.cnt2", 32'(bus2.det_cnt), 32'd3);
        check("sat2.cnt8", 32'(bus8.det_cnt), 32'd5);
`endif

        // Random bits, occasional reset
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0), "rand");
        end

        // Drive the 8-bit counter past saturation
        step(1'b0, 1'b1, "rst");
        for (int i = 0; i < 260; i++) detect3("sat8");
`ifdef SEQDET_CNT_EN
        check("sat8.cnt8", 32'(bus8.det_cnt), 32'd255);
`endif
        check("sb.empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seqdet_core.md
SEQDET_CORE -- requirements
Module: seqdet

Interface
REQ-001 Parameter CNT_W, default 8: width of the detection counter; legal range 2..16.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 x  input  1  serial data bit, sampled on every rising edge of clk.
REQ-005 z  output  1  detect flag; Moore output decoded from the state register only.
REQ-006 q1  output  1  state register bit 1, driven directly from the flop.
REQ-007 q0  output  1  state register bit 0, driven directly from the flop.
REQ-008 det_cnt  output  CNT_W  saturating count of detections; present only when SEQDET_CNT_EN is defined.

Function
REQ-009 The block SHALL be a 4-state Moore FSM that detects the serial pattern 1,1,0 (oldest bit first), with overlapping detection.
REQ-010 State encoding {q1,q0} SHALL be: S0=00 (idle/no match), S1=01 (seen "1"), S11=10 (seen "11"), DET=11 (seen "110").
REQ-011 Transitions SHALL be:
- S0: x=1 -> S1; x=0 -> S0.
- S1: x=1 -> S11; x=0 -> S0.
- S11: x=1 -> S11; x=0 -> DET.
- DET: x=1 -> S1; x=0 -> S0.
REQ-012 z SHALL be 1 only in DET and 0 in all other states, with no combinational path from x to z.
REQ-013 z SHALL assert in the cycle after the edge that samples the final 0 and SHALL last exactly one cycle per detection.
REQ-014 Any run of three or more 1s followed by 0 SHALL produce exactly one detection.
REQ-015 Next-state logic SHALL be fully specified for all four encodings, so that no latch and no unreachable lock-up state exists.

Reset
REQ-016 When reset=1 at a rising clk edge, the state SHALL become S0, giving q1=0, q0=0 and z=0; det_cnt SHALL become 0.
REQ-017 Reset SHALL override x and SHALL take effect from any state, including DET mid-detection.
REQ-018 Outputs SHALL not change asynchronously on reset assertion; the first sample of x after release occurs on the first edge with reset=0.

Configuration
REQ-019 With macro SEQDET_CNT_EN defined:
- port det_cnt SHALL exist.
- det_cnt SHALL increment by 1 on each edge where the next state is DET.
- det_cnt SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-020 Without SEQDET_CNT_EN:
- det_cnt and its logic SHALL be absent.
- FSM behaviour SHALL be identical in both builds.

Verification
REQ-021 Hold reset=1 for 6 cycles with x=0 and x=1 -> q1q0=00 and z=0 throughout.
REQ-022 After reset release, apply x=1,0,0,1,0,1,1,0,1,1,1 on successive edges:
- state sequence SHALL be S1,S0,S0,S1,S0,S1,S11,DET,S1,S11,S11.
- z=1 only after the 8th bit.
REQ-023 Apply x=1,1,1,1,0 -> z=1 for exactly one cycle, after the 0; det_cnt=1 (SEQDET_CNT_EN build).
REQ-024 Apply x=1,1,0,1,1,0 -> two separate single-cycle z pulses, three cycles apart; det_cnt=2.
REQ-025 Assert reset in the cycle the FSM is in DET -> next state S0, z=0, det_cnt=0.
REQ-026 Build with CNT_W=2 and apply five detections -> det_cnt holds 3 (saturated).
